// File: rtl/srcnn_pkg.sv
// Shared types for the SRCNN frame scheduler: path selection, dispatch states and pixel width.
package srcnn_pkg;

    localparam int unsigned ActivationWidth = 8;
    localparam int unsigned PixelWidth      = 3 * ActivationWidth;

    typedef enum logic {
        PathBypass = 1'b0,
        PathSrcnn  = 1'b1
    } path_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StRoute = 1'b1
    } state_e;

endpackage

// File: rtl/frame_order_fifo.sv
// Small registered FIFO recording which path each in-flight frame took, in dispatch order.
module frame_order_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock_i,
    input  logic                         reset_ni,
    input  logic                         push_i,
    input  logic                         data_i,
    input  logic                         pop_i,
    output logic                         data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AddrWidth  = $clog2(DEPTH);
    localparam int unsigned PtrWidth   = AddrWidth + 1;
    localparam int unsigned CountWidth = $clog2(DEPTH + 1);

    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic                r_mem [DEPTH];
    logic                w_do_push;
    logic                w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign full_o    = (r_wr_ptr[PtrWidth-1] != r_rd_ptr[PtrWidth-1]) &&
                       (r_wr_ptr[AddrWidth-1:0] == r_rd_ptr[AddrWidth-1:0]);
    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign data_o    = r_mem[r_rd_ptr[AddrWidth-1:0]];
    assign count_o   = CountWidth'(r_wr_ptr - r_rd_ptr);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 1'b0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AddrWidth-1:0]] <= data_i;
                r_wr_ptr                       <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            end
        end
    end

endmodule

// File: rtl/srcnn_frame_scheduler.sv
// Routes whole frames to the SRCNN or bypass path and re-merges both returns in dispatch order.
module srcnn_frame_scheduler
    import srcnn_pkg::*;
#(
    parameter int unsigned HEIGHT     = 600,
    parameter int unsigned WIDTH      = 800,
    parameter int unsigned DATA_WIDTH = PixelWidth,
    parameter int unsigned MAX_FRAMES = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_ni,
    input  logic                           mode_i,

    input  logic                           slave_tvalid_i,
    output logic                           slave_tready_o,
    input  logic [DATA_WIDTH-1:0]          slave_tdata_i,
    input  logic                           slave_tlast_i,

    output logic                           srcnn_in_tvalid_o,
    input  logic                           srcnn_in_tready_i,
    output logic [DATA_WIDTH-1:0]          srcnn_in_tdata_o,
    output logic                           srcnn_in_tlast_o,

    input  logic                           srcnn_out_tvalid_i,
    output logic                           srcnn_out_tready_o,
    input  logic [DATA_WIDTH-1:0]          srcnn_out_tdata_i,
    input  logic                           srcnn_out_tlast_i,

    output logic                           byp_in_tvalid_o,
    input  logic                           byp_in_tready_i,
    output logic [DATA_WIDTH-1:0]          byp_in_tdata_o,
    output logic                           byp_in_tlast_o,

    input  logic                           byp_out_tvalid_i,
    output logic                           byp_out_tready_o,
    input  logic [DATA_WIDTH-1:0]          byp_out_tdata_i,
    input  logic                           byp_out_tlast_i,

    output logic                           master_tvalid_o,
    input  logic                           master_tready_i,
    output logic [DATA_WIDTH-1:0]          master_tdata_o,
    output logic                           master_tlast_o,

    output logic [$clog2(MAX_FRAMES+1)-1:0] frames_in_flight_o,
    output logic                           tlast_error_o
);

    localparam int unsigned FrameBeats = HEIGHT * WIDTH;
    localparam int unsigned CountWidth = $clog2(FrameBeats);

    state_e                r_state;
    state_e                w_state_next;
    path_e                 r_sel;
    logic [CountWidth-1:0] r_count;
    logic                  r_tlast_err;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_head_raw;
    path_e                 w_head;

    assign w_last_beat   = (r_count == CountWidth'(FrameBeats - 1));
    assign w_accept      = slave_tvalid_i && slave_tready_o;
    assign w_head        = path_e'(w_head_raw);
    assign w_pop         = master_tvalid_o && master_tready_i && master_tlast_o;
    assign tlast_error_o = r_tlast_err;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (slave_tvalid_i && !w_fifo_full) w_state_next = StRoute;
            StRoute: if (w_accept && w_last_beat)        w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Dispatch outputs: one idle cycle to log the path, then pass-through to the chosen path only.
    always_comb begin
        w_push            = 1'b0;
        slave_tready_o    = 1'b0;
        srcnn_in_tvalid_o = 1'b0;
        srcnn_in_tdata_o  = '0;
        srcnn_in_tlast_o  = 1'b0;
        byp_in_tvalid_o   = 1'b0;
        byp_in_tdata_o    = '0;
        byp_in_tlast_o    = 1'b0;
        case (r_state)
            StIdle: begin
                w_push = slave_tvalid_i && !w_fifo_full;
            end
            StRoute: begin
                if (r_sel == PathSrcnn) begin
                    srcnn_in_tvalid_o = slave_tvalid_i;
                    srcnn_in_tdata_o  = slave_tdata_i;
                    srcnn_in_tlast_o  = w_last_beat;
                    slave_tready_o    = srcnn_in_tready_i;
                end else begin
                    byp_in_tvalid_o   = slave_tvalid_i;
                    byp_in_tdata_o    = slave_tdata_i;
                    byp_in_tlast_o    = w_last_beat;
                    slave_tready_o    = byp_in_tready_i;
                end
            end
            default: ;
        endcase
    end

    // Pixel counter is authoritative for frame boundaries; upstream tlast is only checked.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sel       <= PathBypass;
            r_count     <= '0;
            r_tlast_err <= 1'b0;
        end else begin
            r_tlast_err <= w_accept && (slave_tlast_i != w_last_beat);
            if (w_push) begin
                r_sel <= path_e'(mode_i);
            end
            if (w_accept) begin
                r_count <= w_last_beat ? '0 : r_count + CountWidth'(1);
            end
        end
    end

    // Merge: the oldest in-flight frame owns the master port until its tlast is accepted.
    always_comb begin
        master_tvalid_o    = 1'b0;
        master_tdata_o     = '0;
        master_tlast_o     = 1'b0;
        srcnn_out_tready_o = 1'b0;
        byp_out_tready_o   = 1'b0;
        if (!w_fifo_empty) begin
            if (w_head == PathSrcnn) begin
                master_tvalid_o    = srcnn_out_tvalid_i;
                master_tdata_o     = srcnn_out_tdata_i;
                master_tlast_o     = srcnn_out_tlast_i;
                srcnn_out_tready_o = master_tready_i;
            end else begin
                master_tvalid_o    = byp_out_tvalid_i;
                master_tdata_o     = byp_out_tdata_i;
                master_tlast_o     = byp_out_tlast_i;
                byp_out_tready_o   = master_tready_i;
            end
        end
    end

    frame_order_fifo #(
        .DEPTH (MAX_FRAMES)
    ) u_order_fifo (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .push_i   (w_push),
        .data_i   (mode_i),
        .pop_i    (w_pop),
        .data_o   (w_head_raw),
        .full_o   (w_fifo_full),
        .empty_o  (w_fifo_empty),
        .count_o  (frames_in_flight_o)
    );

endmodule
